// File: rtl/lsu.sv
// Load/store unit: aligns one access, runs req/gnt/rvalid on the data port, returns extended load data.
// Build option LSU_MISALIGN_CHECK_EN rejects misaligned half/word accesses and size 2'b11 without a bus access.
module lsu #(
  parameter int BUS_TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  input  logic        data_err_i
);

`ifdef LSU_MISALIGN_CHECK_EN
  localparam bit MisalignCheck = 1'b1;
`else
  localparam bit MisalignCheck = 1'b0;
`endif

  localparam int CNT_W = (BUS_TIMEOUT_CYCLES > 0) ? $clog2(BUS_TIMEOUT_CYCLES + 1) : 1;
  localparam bit TmoEn = (BUS_TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TmoLast = CNT_W'((BUS_TIMEOUT_CYCLES > 0) ? BUS_TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [31:0]      addr_q, wdata_q, rdata_q;
  logic [1:0]       size_q;
  logic             we_q, uns_q;

  function automatic logic illegal_f(input logic [1:0] size, input logic [1:0] a);
    logic bad;
    case (size)
      2'b01:   bad = a[0];
      2'b10:   bad = |a;
      2'b11:   bad = 1'b1;
      default: bad = 1'b0;
    endcase
    return MisalignCheck && bad;
  endfunction

  // Halves always use lane a[1]*2; identical to a[1:0] whenever the alignment check passes.
  function automatic logic [3:0] be_f(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   return 4'b0001 << a;
      2'b01:   return 4'b0011 << {a[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wdata_f(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] load_f(input logic [1:0] size, input logic uns,
                                         input logic [1:0] a, input logic [31:0] word);
    logic [31:0]        shb, shh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    shb = word >> {a, 3'b000};
    shh = word >> {a[1], 4'b0000};
    b   = $signed(shb[7:0]);
    h   = $signed(shh[15:0]);
    case (size)
      2'b00:   return uns ? {24'b0, shb[7:0]} : 32'(b);
      2'b01:   return uns ? {16'b0, shh[15:0]} : 32'(h);
      default: return word;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          if (illegal_f(req_size_i, req_addr_i[1:0])) begin
            state_d = RESP;
            err_d   = 1'b1;
          end else begin
            state_d = REQ;
            err_d   = 1'b0;
            cnt_d   = '0;
          end
        end
      end
      REQ: begin
        // A grant in the cycle the timeout fires still wins.
        if (data_gnt_i) begin
          state_d = WAIT;
        end else if (TmoEn && (cnt_q == TmoLast)) begin
          state_d = RESP;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT: begin
        if (data_rvalid_i) begin
          state_d = RESP;
          err_d   = data_err_i;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Access payload is not reset: every output that exposes it is gated by state.
  always_ff @(posedge clk_i) begin
    if (state_q == IDLE && req_valid_i) begin
      addr_q  <= req_addr_i;
      size_q  <= req_size_i;
      we_q    <= req_we_i;
      uns_q   <= req_unsigned_i;
      wdata_q <= req_wdata_i;
    end
    if (state_q == WAIT && data_rvalid_i) begin
      rdata_q <= data_rdata_i;
    end
  end

  assign req_ready_o  = (state_q == IDLE) && !rst_i;
  assign data_req_o   = (state_q == REQ);
  assign data_addr_o  = data_req_o ? {addr_q[31:2], 2'b00} : '0;
  assign data_we_o    = data_req_o && we_q;
  assign data_be_o    = data_req_o ? be_f(size_q, addr_q[1:0]) : '0;
  assign data_wdata_o = (data_req_o && we_q) ? wdata_f(size_q, wdata_q) : '0;
  assign resp_valid_o = (state_q == RESP);
  assign resp_err_o   = resp_valid_o && err_q;
  assign resp_rdata_o = (resp_valid_o && !err_q && !we_q) ?
                        load_f(size_q, uns_q, addr_q[1:0], rdata_q) : '0;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: driver queues expected responses, a memory responder follows a per-access plan,
// and a monitor pops and compares every response.
`timescale 1ns/1ps
module tb_lsu;
  localparam int TMO = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i, req_ready_o, req_we_i, req_unsigned_i;
  logic [1:0]  req_size_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic        resp_valid_o, resp_err_o;
  logic [31:0] resp_rdata_o;
  logic        data_req_o, data_gnt_i, data_we_o, data_rvalid_i, data_err_i;
  logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
  logic [3:0]  data_be_o;

  lsu #(.BUS_TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o),
    .resp_err_o(resp_err_o), .data_req_o(data_req_o), .data_gnt_i(data_gnt_i),
    .data_addr_o(data_addr_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_wdata_o(data_wdata_o), .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i),
    .data_err_i(data_err_i)
  );

  always #5 clk_i = ~clk_i;

  int unsigned cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          gdly;
    int          rdly;
  } plan_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned cyc;
  } exp_t;

  plan_t plan_q[$];
  exp_t  exp_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_illegal(input logic [1:0] size, input logic [31:0] a);
    bit bad = 0;
`ifdef LSU_MISALIGN_CHECK_EN
    if (size == 2'd3) bad = 1;
    if (size == 2'd1 && (a % 2) != 0) bad = 1;
    if (size == 2'd2 && (a % 4) != 0) bad = 1;
`endif
    return bad;
  endfunction

  function automatic int m_bytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic int m_off(input logic [1:0] size, input logic [31:0] a);
    int n = m_bytes(size);
    return (int'(a % 4) / n) * n;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] size, input logic [31:0] a);
    return 4'(((1 << m_bytes(size)) - 1) << m_off(size, a));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] r;
    int n = m_bytes(size);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] size, input logic uns,
                                         input logic [31:0] a, input logic [31:0] w);
    int     n   = m_bytes(size);
    longint lim = longint'(1) << (8 * n);
    longint v   = longint'(w >> (8 * m_off(size, a))) % lim;
    if (!uns && n < 4 && v >= lim / 2) v = v - lim;
    return v[31:0];
  endfunction

  // ---------------- driver ----------------
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdata, input logic err, input int gdly, input int rdly);
    plan_t p;
    exp_t  e;
    int    guard = 0;
    while (!req_ready_o) begin
      @(negedge clk_i);
      guard++;
      if (guard > 100) begin
        chk("ready_wait", 64'(req_ready_o), 64'(1));
        break;
      end
    end
    req_valid_i = 1'b1; req_we_i = we; req_size_i = size; req_unsigned_i = uns;
    req_addr_i = addr; req_wdata_i = wdata;
    if (m_illegal(size, addr)) begin
      e.rdata = '0; e.err = 1'b1; e.cyc = cyc + 1;
    end else begin
      p.addr = addr; p.we = we; p.be = m_be(size, addr);
      p.wdata = m_wdata(size, wdata); p.rdata = rdata; p.err = err;
      p.gdly = gdly; p.rdly = rdly;
      plan_q.push_back(p);
      if (gdly >= TMO) begin
        e.rdata = '0; e.err = 1'b1; e.cyc = cyc + TMO + 1;
      end else begin
        e.err   = err;
        e.rdata = (err || we) ? 32'h0 : m_load(size, uns, addr, rdata);
        e.cyc   = cyc + 3 + gdly + rdly;
      end
    end
    exp_q.push_back(e);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    req_we_i = 1'($urandom); req_size_i = 2'($urandom); req_addr_i = $urandom; req_wdata_i = $urandom;
  endtask

  // ---------------- memory responder ----------------
  initial begin
    int    phase = 0;
    int    cnt = 0;
    plan_t cur;
    data_gnt_i = 0; data_rvalid_i = 0; data_err_i = 0; data_rdata_i = 0;
    forever begin
      @(negedge clk_i);
      data_gnt_i    = 1'b0;
      data_rvalid_i = ($urandom_range(0, 7) == 0);
      data_err_i    = 1'($urandom);
      data_rdata_i  = $urandom;
      if (phase == 0 && data_req_o) begin
        if (plan_q.size() == 0) chk("unexpected_bus_req", 64'(data_req_o), 64'(0));
        else begin
          cur = plan_q.pop_front();
          phase = 1;
          cnt = 0;
        end
      end
      if (phase == 1) begin
        if (!data_req_o) begin
          if (cur.gdly >= TMO) chk("tmo_req_cycles", 64'(cnt), 64'(TMO));
          else chk("req_dropped_early", 64'(data_req_o), 64'(1));
          phase = 0;
        end else begin
          chk("bus_addr", 64'(data_addr_o), 64'({cur.addr[31:2], 2'b00}));
          chk("bus_we", 64'(data_we_o), 64'(cur.we));
          chk("bus_be", 64'(data_be_o), 64'(cur.be));
          if (cur.we) chk("bus_wdata", 64'(data_wdata_o), 64'(cur.wdata));
          if (cnt == cur.gdly) begin
            data_gnt_i = 1'b1;
            phase = 2;
            cnt = 0;
          end else cnt++;
        end
      end else if (phase == 2) begin
        chk("req_low_in_wait", 64'(data_req_o), 64'(0));
        data_rvalid_i = 1'b0;
        if (cnt == cur.rdly) begin
          data_rvalid_i = 1'b1; data_rdata_i = cur.rdata; data_err_i = cur.err;
          phase = 0;
        end else cnt++;
      end
    end
  end

  // ---------------- response monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (resp_valid_o) begin
        if (exp_q.size() == 0) chk("unexpected_resp", 64'(resp_valid_o), 64'(0));
        else begin
          e = exp_q.pop_front();
          chk("resp_cycle", 64'(cyc), 64'(e.cyc));
          chk("resp_err", 64'(resp_err_o), 64'(e.err));
          chk("resp_rdata", 64'(resp_rdata_o), 64'(e.rdata));
        end
      end else if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
        chk("resp_missing", 64'(resp_valid_o), 64'(1));
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int guard;
    rst_i = 1'b1; req_valid_i = 0; req_we_i = 0; req_size_i = 0; req_unsigned_i = 0;
    req_addr_i = 0; req_wdata_i = 0;
    repeat (3) @(negedge clk_i);
    chk("rst_ready", 64'(req_ready_o), 64'(0));
    chk("rst_data_req", 64'(data_req_o), 64'(0));
    chk("rst_resp_valid", 64'(resp_valid_o), 64'(0));
    chk("rst_resp_err", 64'(resp_err_o), 64'(0));
    chk("rst_resp_rdata", 64'(resp_rdata_o), 64'(0));
    chk("rst_bus_fields", 64'({data_addr_o, data_be_o, data_we_o}), 64'(0));
    chk("rst_bus_wdata", 64'(data_wdata_o), 64'(0));
    rst_i = 1'b0;
    #1 chk("ready_after_rst", 64'(req_ready_o), 64'(1));

    // Directed: sign/zero extension, store lanes, misalignment, timeouts, bus error.
    issue(0, 2'd0, 0, 32'h0000_1003, 32'h0, 32'h80FF_0000, 0, 0, 0);
    issue(0, 2'd0, 1, 32'h0000_1003, 32'h0, 32'h80FF_0000, 0, 0, 0);
    issue(1, 2'd1, 0, 32'h0000_2002, 32'h1234_ABCD, 32'h5555_5555, 0, 0, 0);
    issue(0, 2'd2, 0, 32'h0000_3001, 32'h0, 32'hCAFE_F00D, 0, 0, 0);
    issue(0, 2'd1, 0, 32'h0000_4002, 32'h0, 32'h8001_1234, 0, 1, 2);
    issue(0, 2'd1, 1, 32'h0000_4002, 32'h0, 32'h8001_1234, 0, 0, 1);
    issue(0, 2'd3, 0, 32'h0000_5000, 32'h0, 32'h9ABC_DEF0, 0, 0, 0);
    issue(0, 2'd2, 0, 32'h0000_6000, 32'h0, 32'h1111_2222, 0, 99, 0);
    issue(1, 2'd2, 0, 32'h0000_6004, 32'hA5A5_5A5A, 32'h0, 0, TMO - 1, 0);
    issue(0, 2'd2, 0, 32'h0000_7000, 32'h0, 32'h7777_7777, 1, 0, 1);

    // Reset while waiting for rvalid; the late rvalid must be ignored.
    issue(0, 2'd2, 0, 32'h0000_8000, 32'h0, 32'hDEAD_BEEF, 0, 0, 1);
    void'(exp_q.pop_back());
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("rst_mid_data_req", 64'(data_req_o), 64'(0));
    chk("rst_mid_resp", 64'(resp_valid_o), 64'(0));
    rst_i = 1'b0;
    #1 chk("ready_after_mid_rst", 64'(req_ready_o), 64'(1));

    for (int i = 0; i < 300; i++) begin
      int r = $urandom_range(0, 9);
      int g = (r < 6) ? 0 : (r < 8) ? $urandom_range(1, 2) : (r == 8) ? TMO - 1 : 99;
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
      issue(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
            ($urandom_range(0, 7) == 0), g, $urandom_range(0, 3));
    end

    guard = 0;
    while (exp_q.size() > 0 && guard < 200) begin
      @(negedge clk_i);
      guard++;
    end
    chk("drain", 64'(exp_q.size()), 64'(0));
    repeat (3) @(negedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    miscompares++;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
